// File: rtl/traffic_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_countdown_ctrl
//
// Two-way traffic light controller with a two-digit BCD countdown display.
// A prescaler divides clk down to a countdown tick. Each tick decrements the
// remaining-time display of the current phase. When the display reaches 01,
// the next tick moves the controller to the following phase. Night mode
// overrides the sequence: both yellow lamps flash and the display is blanked.
//
// Ports
//   clk          in   1  system clock, rising edge
//   rst_N        in   1  asynchronous active-low reset
//   run          in   1  1 = countdown and prescaler advance, 0 = freeze
//   night        in   1  1 = night mode (flashing yellow, display blanked)
//   number_BCD   out  8  remaining ticks of the phase, {tens, ones} in BCD
//   disp_enable  out  1  enable for the 2-digit tube driver
//   lights_ns    out  3  north-south lamps {red, yellow, green}
//   lights_ew    out  3  east-west lamps {red, yellow, green}
//   phase_done   out  1  one-cycle pulse after each countdown phase change
//
// States
//   state     | meaning
//   ----------+------------------------------------------------
//   NS_GREEN  | north-south go, east-west stop
//   NS_YELLOW | north-south clearing, east-west stop
//   EW_GREEN  | east-west go, north-south stop
//   EW_YELLOW | east-west clearing, north-south stop
//   NIGHT     | both yellows flash on each tick, display blanked
// -----------------------------------------------------------------------------
module traffic_countdown_ctrl #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TICK_HZ     = 1,
    parameter int GREEN_S     = 25,
    parameter int YELLOW_S    = 3
) (
    input  logic       clk,
    input  logic       rst_N,
    input  logic       run,
    input  logic       night,
    output logic [7:0] number_BCD,
    output logic       disp_enable,
    output logic [2:0] lights_ns,
    output logic [2:0] lights_ew,
    output logic       phase_done
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);

    // Binary to two-digit BCD. This is only evaluated on constants.
    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    localparam logic [7:0] GREEN_BCD  = to_bcd(GREEN_S);
    localparam logic [7:0] YELLOW_BCD = to_bcd(YELLOW_S);

    typedef enum logic [2:0] {
        NS_GREEN,
        NS_YELLOW,
        EW_GREEN,
        EW_YELLOW,
        NIGHT
    } state_t;

    state_t          state;
    logic [PW-1:0]   prescaler;
    logic            flash;
    logic            tick;

    assign tick = (prescaler == PW'(DIV - 1));

    // BCD decrement. A ones digit of 0 borrows from the tens digit.
    // The value 00 never reaches this function, because 01 causes a phase
    // change instead of a decrement.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state       <= NS_GREEN;
            number_BCD  <= GREEN_BCD;
            prescaler   <= '0;
            flash       <= 1'b0;
            disp_enable <= 1'b1;
            lights_ns   <= 3'b001;
            lights_ew   <= 3'b100;
            phase_done  <= 1'b0;
        end else begin
            phase_done <= 1'b0;
            if (night) begin
                if (state != NIGHT) begin
                    // Enter night mode with both yellows lit. The prescaler
                    // restarts so that the first toggle comes one full tick
                    // period later.
                    state       <= NIGHT;
                    prescaler   <= '0;
                    flash       <= 1'b1;
                    number_BCD  <= 8'h00;
                    disp_enable <= 1'b0;
                    lights_ns   <= 3'b010;
                    lights_ew   <= 3'b010;
                end else if (tick) begin
                    prescaler <= '0;
                    flash     <= ~flash;
                    lights_ns <= {1'b0, ~flash, 1'b0};
                    lights_ew <= {1'b0, ~flash, 1'b0};
                end else begin
                    prescaler <= prescaler + PW'(1);
                end
            end else if (state == NIGHT) begin
                state       <= NS_GREEN;
                number_BCD  <= GREEN_BCD;
                prescaler   <= '0;
                flash       <= 1'b0;
                disp_enable <= 1'b1;
                lights_ns   <= 3'b001;
                lights_ew   <= 3'b100;
            end else if (run) begin
                if (tick) begin
                    prescaler <= '0;
                    if (number_BCD == 8'h01) begin
                        phase_done <= 1'b1;
                        case (state)
                            NS_GREEN: begin
                                state      <= NS_YELLOW;
                                number_BCD <= YELLOW_BCD;
                                lights_ns  <= 3'b010;
                                lights_ew  <= 3'b100;
                            end
                            NS_YELLOW: begin
                                state      <= EW_GREEN;
                                number_BCD <= GREEN_BCD;
                                lights_ns  <= 3'b100;
                                lights_ew  <= 3'b001;
                            end
                            EW_GREEN: begin
                                state      <= EW_YELLOW;
                                number_BCD <= YELLOW_BCD;
                                lights_ns  <= 3'b100;
                                lights_ew  <= 3'b010;
                            end
                            default: begin
                                state      <= NS_GREEN;
                                number_BCD <= GREEN_BCD;
                                lights_ns  <= 3'b001;
                                lights_ew  <= 3'b100;
                            end
                        endcase
                    end else begin
                        number_BCD <= bcd_dec(number_BCD);
                    end
                end else begin
                    prescaler <= prescaler + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_countdown_ctrl.sv
module tb_traffic_countdown_ctrl;

    localparam int CLK_HZ = 10;
    localparam int T_HZ   = 1;
    localparam int DIV    = CLK_HZ / T_HZ;
    localparam int G      = 12;
    localparam int Y      = 3;

    logic       clk = 1'b0;
    logic       rst_N;
    logic       run;
    logic       night;

    logic [7:0] number_BCD;
    logic       disp_enable;
    logic [2:0] lights_ns, lights_ew;
    logic       phase_done;

    logic [7:0] g1_number;
    logic       g1_disp;
    logic [2:0] g1_ns, g1_ew;
    logic       g1_done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    traffic_countdown_ctrl #(
        .CLK_FREQ_HZ(CLK_HZ), .TICK_HZ(T_HZ), .GREEN_S(G), .YELLOW_S(Y)
    ) dut (
        .clk(clk), .rst_N(rst_N), .run(run), .night(night),
        .number_BCD(number_BCD), .disp_enable(disp_enable),
        .lights_ns(lights_ns), .lights_ew(lights_ew), .phase_done(phase_done)
    );

    // Build with one-tick phases.
    traffic_countdown_ctrl #(
        .CLK_FREQ_HZ(CLK_HZ), .TICK_HZ(T_HZ), .GREEN_S(1), .YELLOW_S(1)
    ) dut_g1 (
        .clk(clk), .rst_N(rst_N), .run(run), .night(night),
        .number_BCD(g1_number), .disp_enable(g1_disp),
        .lights_ns(g1_ns), .lights_ew(g1_ew), .phase_done(g1_done)
    );

    // ---------------- behavioural model --------------------------------
    // Phase 0..3 = NS green, NS yellow, EW green, EW yellow.
    // rem holds the remaining ticks as a plain integer.
    int   m_phase, m_rem, m_pre;
    bit   m_night, m_flash, m_done;

    function automatic int phase_len(input int p);
        return (p % 2 == 0) ? G : Y;
    endfunction

    function automatic logic [7:0] dec2bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    always @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            m_phase <= 0; m_rem <= G; m_pre <= 0;
            m_night <= 1'b0; m_flash <= 1'b0; m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (night) begin
                if (!m_night) begin
                    m_night <= 1'b1; m_pre <= 0; m_flash <= 1'b1;
                end else if (m_pre == DIV - 1) begin
                    m_pre <= 0; m_flash <= ~m_flash;
                end else begin
                    m_pre <= m_pre + 1;
                end
            end else if (m_night) begin
                m_night <= 1'b0; m_phase <= 0; m_rem <= G; m_pre <= 0;
            end else if (run) begin
                if (m_pre == DIV - 1) begin
                    m_pre <= 0;
                    if (m_rem == 1) begin
                        m_phase <= (m_phase + 1) % 4;
                        m_rem   <= phase_len((m_phase + 1) % 4);
                        m_done  <= 1'b1;
                    end else begin
                        m_rem <= m_rem - 1;
                    end
                end else begin
                    m_pre <= m_pre + 1;
                end
            end
        end
    end

    function automatic logic [2:0] exp_ns();
        if (m_night) return m_flash ? 3'b010 : 3'b000;
        case (m_phase)
            0: return 3'b001;
            1: return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_ew();
        if (m_night) return m_flash ? 3'b010 : 3'b000;
        case (m_phase)
            2: return 3'b001;
            3: return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // Compare the outputs against the model on every cycle.
    always @(negedge clk) begin
        logic [7:0] e_num;
        e_num = m_night ? 8'h00 : dec2bcd(m_rem);
        n_checks++;
        if (number_BCD !== e_num || disp_enable !== !m_night ||
            lights_ns !== exp_ns() || lights_ew !== exp_ew() ||
            phase_done !== m_done) begin
            n_fail++;
            $display("FAIL model t=%0t got num=%h en=%b ns=%b ew=%b pd=%b expected num=%h en=%b ns=%b ew=%b pd=%b",
                     $time, number_BCD, disp_enable, lights_ns, lights_ew, phase_done,
                     e_num, !m_night, exp_ns(), exp_ew(), m_done);
        end
        if (phase_done === 1'b1) done_cnt++;
    end

    // ---------------- directed literal checks ---------------------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_N = 1'b0; run = 1'b0; night = 1'b0;
        step(3);
        chk("rst_num", number_BCD, 8'h12);
        chk("rst_en", {7'd0, disp_enable}, 8'h01);
        chk("rst_ns", {5'd0, lights_ns}, 8'h01);
        chk("rst_ew", {5'd0, lights_ew}, 8'h04);
        chk("rst_pd", {7'd0, phase_done}, 8'h00);
        chk("g1_rst_num", g1_number, 8'h01);

        rst_N = 1'b1; run = 1'b1;
        done_cnt = 0;
        step(9);
        chk("num_9", number_BCD, 8'h12);
        chk("g1_num_9", g1_number, 8'h01);
        chk("g1_ns_9", {5'd0, g1_ns}, 8'h01);
        step(1);
        chk("num_10", number_BCD, 8'h11);
        chk("g1_num_10", g1_number, 8'h01);
        chk("g1_ns_10", {5'd0, g1_ns}, 8'h02);
        chk("g1_pd_10", {7'd0, g1_done}, 8'h01);
        step(10);
        chk("num_20", number_BCD, 8'h10);
        chk("g1_ns_20", {5'd0, g1_ns}, 8'h04);
        chk("g1_ew_20", {5'd0, g1_ew}, 8'h01);
        step(10);
        chk("num_30_borrow", number_BCD, 8'h09);
        step(89);
        chk("num_119", number_BCD, 8'h01);
        chk("done_cnt_119", 8'(done_cnt), 8'd0);
        step(1);
        chk("num_120", number_BCD, 8'h03);
        chk("ns_120", {5'd0, lights_ns}, 8'h02);
        chk("ew_120", {5'd0, lights_ew}, 8'h04);
        chk("pd_120", {7'd0, phase_done}, 8'h01);
        step(1);
        chk("pd_121", {7'd0, phase_done}, 8'h00);
        chk("done_cnt_121", 8'(done_cnt), 8'd1);
        step(29);
        chk("num_150", number_BCD, 8'h12);
        chk("ns_150", {5'd0, lights_ns}, 8'h04);
        chk("ew_150", {5'd0, lights_ew}, 8'h01);

        // Freeze in the middle of a tick period.
        step(5);
        run = 1'b0;
        step(50);
        chk("frz_num", number_BCD, 8'h12);
        chk("frz_ew", {5'd0, lights_ew}, 8'h01);
        chk("frz_en", {7'd0, disp_enable}, 8'h01);
        run = 1'b1;
        step(4);
        chk("resume_4", number_BCD, 8'h12);
        step(1);
        chk("resume_5", number_BCD, 8'h11);

        // Night mode with run low.
        night = 1'b1; run = 1'b0;
        step(1);
        chk("nt_en", {7'd0, disp_enable}, 8'h00);
        chk("nt_num", number_BCD, 8'h00);
        chk("nt_ns0", {5'd0, lights_ns}, 8'h02);
        chk("nt_ew0", {5'd0, lights_ew}, 8'h02);
        step(9);
        chk("nt_ns9", {5'd0, lights_ns}, 8'h02);
        step(1);
        chk("nt_ns10", {5'd0, lights_ns}, 8'h00);
        chk("nt_ew10", {5'd0, lights_ew}, 8'h00);
        step(10);
        chk("nt_ns20", {5'd0, lights_ns}, 8'h02);
        night = 1'b0;
        step(1);
        chk("nt_exit_num", number_BCD, 8'h12);
        chk("nt_exit_ns", {5'd0, lights_ns}, 8'h01);
        chk("nt_exit_en", {7'd0, disp_enable}, 8'h01);

        // Advance into EW_YELLOW, then apply an asynchronous reset pulse.
        run = 1'b1;
        step(275);
        chk("ewy_ew", {5'd0, lights_ew}, 8'h02);
        #2 rst_N = 1'b0;
        #1;
        chk("arst_num", number_BCD, 8'h12);
        chk("arst_ns", {5'd0, lights_ns}, 8'h01);
        chk("arst_ew", {5'd0, lights_ew}, 8'h04);
        chk("arst_en", {7'd0, disp_enable}, 8'h01);
        #1 rst_N = 1'b1;
        step(10);
        chk("post_rst_10", number_BCD, 8'h11);

        // Apply a reset while in night mode.
        night = 1'b1;
        step(3);
        rst_N = 1'b0;
        step(1);
        night = 1'b0;
        rst_N = 1'b1;
        step(1);
        chk("nt_rst_num", number_BCD, 8'h12);
        chk("nt_rst_ns", {5'd0, lights_ns}, 8'h01);
        step(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
